// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the acc_cpu accumulator core: opcodes, FSM states and
// instruction field positions as functions of the data width.
package acc_cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADDI = 3'b000,
        OP_ANDI = 3'b001,
        OP_JP   = 3'b010,
        OP_INC  = 3'b011,
        OP_JC   = 3'b100,
        OP_LD   = 3'b101,
        OP_ST   = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_OPERAND,
        S_MEMOP,
        S_HALT
    } state_t;

    function automatic int unsigned op_msb(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned data_w);
        return data_w - 3;
    endfunction

    function automatic int unsigned imm_msb(input int unsigned data_w);
        return data_w - 4;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ADDI/ANDI/INC datapath for acc_cpu; carry taken from bit DATA_W.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] imm,
    input  logic              carry_in,
    output logic [DATA_W-1:0] acc_next,
    output logic              carry_next
);

    logic [DATA_W:0] sum;

    always_comb begin
        acc_next   = acc;
        carry_next = carry_in;
        sum        = '0;
        case (opcode_t'(op))
            OP_ADDI: begin
                sum                   = {1'b0, acc} + {1'b0, imm};
                {carry_next, acc_next} = sum;
            end
            OP_ANDI: acc_next = acc & imm;
            OP_INC: begin
                sum                   = {1'b0, acc} + (DATA_W + 1)'(1);
                {carry_next, acc_next} = sum;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu.sv
// Multi-cycle single-accumulator CPU with req/ready memory port.
// Define ACC_CPU_LDST_EN to enable LD/ST memory operations.
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              carry_out,
    output logic              halted
);

    localparam int unsigned OP_MSB  = op_msb(DATA_W);
    localparam int unsigned OP_LSB  = op_lsb(DATA_W);
    localparam int unsigned IMM_MSB = imm_msb(DATA_W);
    localparam int unsigned OPND_W  = (DATA_W > ADDR_W) ? ADDR_W : DATA_W;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc, addr_o, operand;
    logic [DATA_W-1:0] acc, acc_n, ir, ir_n, imm, alu_acc;
    logic              carry, carry_n, alu_carry, req, halted_n;
    logic [2:0]        op;
`ifdef ACC_CPU_LDST_EN
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic              we;
`endif

    assign op     = ir[OP_MSB:OP_LSB];
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        imm              = '0;
        imm[IMM_MSB:0]   = ir[IMM_MSB:0];
        operand          = '0;
        operand[OPND_W-1:0] = mem_rdata[OPND_W-1:0];
    end

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op         (op),
        .acc        (acc),
        .imm        (imm),
        .carry_in   (carry),
        .acc_next   (alu_acc),
        .carry_next (alu_carry)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        carry_n = carry;
        ir_n    = ir;
        req     = 1'b0;
        addr_o  = pc;
`ifdef ACC_CPU_LDST_EN
        addr_n  = addr_r;
        we      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc_inc;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode_t'(op))
                    OP_ADDI, OP_ANDI, OP_INC: begin
                        acc_n   = alu_acc;
                        carry_n = alu_carry;
                        state_n = S_FETCH;
                    end
                    OP_HALT: state_n = S_HALT;
                    default: state_n = S_OPERAND;
                endcase
            end
            S_OPERAND: begin
                req = 1'b1;
                if (mem_ready) begin
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                    case (opcode_t'(op))
                        OP_JP: pc_n = operand;
                        OP_JC: if (carry) pc_n = operand;
`ifdef ACC_CPU_LDST_EN
                        OP_LD, OP_ST: begin
                            addr_n  = operand;
                            state_n = S_MEMOP;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_MEMOP: begin
`ifdef ACC_CPU_LDST_EN
                req    = 1'b1;
                addr_o = addr_r;
                we     = (opcode_t'(op) == OP_ST);
                if (mem_ready) begin
                    if (opcode_t'(op) == OP_LD) acc_n = mem_rdata;
                    state_n = S_FETCH;
                end
`else
                state_n = S_FETCH;
`endif
            end
            S_HALT: ;
            default: state_n = S_FETCH;
        endcase
    end

    assign halted_n = (state_n == S_HALT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_FETCH;
            pc     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            ir     <= '0;
            halted <= 1'b0;
`ifdef ACC_CPU_LDST_EN
            addr_r <= '0;
`endif
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            acc    <= acc_n;
            carry  <= carry_n;
            ir     <= ir_n;
            halted <= halted_n;
`ifdef ACC_CPU_LDST_EN
            addr_r <= addr_n;
`endif
        end
    end

    // Bus outputs are gated by reset so an in-flight access drops immediately.
    assign mem_req   = reset_n & req;
    assign mem_addr  = reset_n ? addr_o : '0;
    assign mem_wdata = reset_n ? acc : '0;
`ifdef ACC_CPU_LDST_EN
    assign mem_we    = reset_n & we;
`else
    assign mem_we    = 1'b0;
`endif

    assign acc_out   = acc;
    assign pc_out    = pc;
    assign carry_out = carry;

endmodule
